// File: rtl/sub_seq_pkg.sv
// Purpose: shared sizes, FSM state type and nibble mux helpers for the sequential subtractor.
// Latency: n/a (package only).
// Backpressure: n/a.
package sub_seq_pkg;

    localparam int WIDTH   = 16;
    localparam int NIB     = 4;
    localparam int NUM_NIB = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_t;

    // Select nibble i of a word. Written as a case so the controller stays mux-only.
    function automatic logic [NIB-1:0] nib_get(input logic [WIDTH-1:0] w, input logic [1:0] i);
        logic [NIB-1:0] r;
        case (i)
            2'd0:    r = w[3:0];
            2'd1:    r = w[7:4];
            2'd2:    r = w[11:8];
            default: r = w[15:12];
        endcase
        return r;
    endfunction

    // Replace nibble i of a word with n.
    function automatic logic [WIDTH-1:0] nib_put(input logic [WIDTH-1:0] w, input logic [1:0] i,
                                                 input logic [NIB-1:0] n);
        logic [WIDTH-1:0] r;
        r = w;
        case (i)
            2'd0:    r[3:0]   = n;
            2'd1:    r[7:4]   = n;
            2'd2:    r[11:8]  = n;
            default: r[15:12] = n;
        endcase
        return r;
    endfunction

    // Next nibble index as a lookup rather than an adder.
    function automatic logic [1:0] nxt_idx(input logic [1:0] i);
        logic [1:0] r;
        case (i)
            2'd0:    r = 2'd1;
            2'd1:    r = 2'd2;
            2'd2:    r = 2'd3;
            default: r = 2'd0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sub_seq_ctrl_nibble_sub.sv
// Purpose: combinational 4-bit borrow-chained subtractor slice (d = a - b - bin).
// Latency: 0 cycles, purely combinational.
// Backpressure: none.
// Ports: a, b (nibble operands), bin (borrow in) -> d (difference), bout (borrow out),
//        ovf (signed overflow of this slice; constant 0 unless SUB_SEQ_OVERFLOW_EN is defined).
module nibble_sub
    import sub_seq_pkg::*;
(
    input  logic [NIB-1:0] a,
    input  logic [NIB-1:0] b,
    input  logic           bin,
    output logic [NIB-1:0] d,
    output logic           bout,
    output logic           ovf
);

    logic [NIB:0] full;

    // The extra top bit of the widened subtraction is the unsigned borrow.
    assign full = {1'b0, a} - {1'b0, b} - {{NIB{1'b0}}, bin};
    assign d    = full[NIB-1:0];
    assign bout = full[NIB];

`ifdef SUB_SEQ_OVERFLOW_EN
    assign ovf = (a[NIB-1] != b[NIB-1]) && (d[NIB-1] != a[NIB-1]);
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: rtl/sub_seq_ctrl.sv
// Purpose: 16-bit a-b computed one nibble per cycle through a single nibble_sub slice.
// Latency: 5 edges from the accepting edge to done (1 accept + 4 nibbles); done pulses one cycle.
// Backpressure: start is ignored while busy; accepted only in IDLE or DONE.
// Ports: clk, rst (sync, active-high); start, a, b in; busy, done, diff, borrow_out, overflow, zero out.
// Optional: SUB_SEQ_OVERFLOW_EN enables signed overflow; otherwise overflow is always 0.
module sub_seq_ctrl
    import sub_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow,
    output logic             zero
);

    sub_state_t       state;
    logic [1:0]       idx;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    // Nibbles accumulate here; diff is only loaded when the whole word is known,
    // so an aborted operation never exposes a partial result.
    logic [WIDTH-1:0] work;
    logic             bchain;

    logic [NIB-1:0]   nib_d;
    logic             nib_bout;
    logic             nib_ovf;
    logic [WIDTH-1:0] final_diff;

    nibble_sub u_nib (
        .a    (nib_get(a_r, idx)),
        .b    (nib_get(b_r, idx)),
        .bin  (bchain),
        .d    (nib_d),
        .bout (nib_bout),
        .ovf  (nib_ovf)
    );

    assign final_diff = {nib_d, work[WIDTH-NIB-1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= 2'd0;
            a_r        <= '0;
            b_r        <= '0;
            work       <= '0;
            bchain     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
            overflow   <= 1'b0;
            zero       <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_r        <= a;
                        b_r        <= b;
                        work       <= '0;
                        bchain     <= 1'b0;
                        idx        <= 2'd0;
                        diff       <= '0;
                        borrow_out <= 1'b0;
                        overflow   <= 1'b0;
                        zero       <= 1'b0;
                        busy       <= 1'b1;
                        state      <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    work   <= nib_put(work, idx, nib_d);
                    bchain <= nib_bout;
                    if (idx == 2'd3) begin
                        diff       <= final_diff;
                        borrow_out <= nib_bout;
                        overflow   <= nib_ovf;
                        zero       <= (final_diff == '0);
                        idx        <= 2'd0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        state      <= DONE;
                    end else begin
                        idx <= nxt_idx(idx);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/sub_seq_ctrl.md
SUB_SEQ_CTRL -- requirements
Module: sub_seq_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port start, input, 1 bit: request to begin one 16-bit subtraction.
REQ-004 SHALL have port a, input, 16 bits: minuend, sampled only on an accepted start.
REQ-005 SHALL have port b, input, 16 bits: subtrahend, sampled only on an accepted start.
REQ-006 SHALL have port busy, output, 1 bit: high while in RUN.
REQ-007 SHALL have port done, output, 1 bit: single-cycle pulse marking valid results.
REQ-008 SHALL have port diff, output, 16 bits: result a-b, modulo 2^16.
REQ-009 SHALL have port borrow_out, output, 1 bit: unsigned borrow, 1 when a<b.
REQ-010 SHALL have port overflow, output, 1 bit: signed two's-complement overflow of a-b.
REQ-011 SHALL have port zero, output, 1 bit: diff==16'h0000.

Function
REQ-012 SHALL compute a-b by sequencing one 4-bit borrow-chained subtractor over nibbles 0..3, LSB nibble first, one nibble per cycle.
REQ-013 SHALL implement states IDLE, RUN and DONE; RUN carries a 2-bit nibble index.
REQ-014 SHALL accept start only in IDLE or DONE, then latch a and b, clear diff, borrow chain, overflow and zero, set index=0 and enter RUN.
REQ-015 SHALL ignore start while in RUN, with no effect on operands, index or results.
REQ-016 SHALL apply borrow-in 0 to nibble 0, and use the registered borrow-out of nibble k as borrow-in of nibble k+1.
REQ-017 SHALL, on each RUN edge, write nibble[index] of diff and increment index; after index 3 it SHALL enter DONE.
REQ-018 SHALL take exactly 5 edges from the edge that accepts start to the edge that leaves RUN: 1 accept edge plus 4 nibble edges.
REQ-019 SHALL assert done for exactly the one cycle spent in DONE, then return to IDLE unless a new start is accepted.
REQ-020 SHALL take borrow_out from the nibble-3 borrow-out.
REQ-021 SHALL take overflow from the nibble-3 signed overflow: (a[15]!=b[15]) && (diff[15]!=a[15]).
REQ-022 SHALL hold diff, borrow_out, overflow and zero stable from DONE until the next accepted start.
REQ-023 SHALL treat a start asserted in DONE as an accept: done still pulses that cycle, and busy rises on the next cycle.

Reset
REQ-024 SHALL, with rst high at a clock edge, force state IDLE, index 0, busy=0, done=0, diff=0, borrow_out=0, overflow=0 and zero=0.
REQ-025 SHALL let rst override start in the same cycle.
REQ-026 SHALL abort any RUN on rst with no done pulse, and the aborted operation's partial results SHALL never appear on the outputs.

Configuration
REQ-027 SHALL, with macro SUB_SEQ_OVERFLOW_EN defined, generate overflow per REQ-021.
REQ-028 SHALL, without SUB_SEQ_OVERFLOW_EN, tie overflow to 0 and omit the overflow logic; all other behaviour SHALL be unchanged.

Structure
REQ-029 SHALL take the following from shared package sub_seq_pkg: WIDTH=16, NIB=4, NUM_NIB=4, and state enum sub_state_t {IDLE,RUN,DONE}.
REQ-030 SHALL instantiate a single sub-module, nibble_sub, as the combinational 4-bit datapath with inputs a[3:0], b[3:0], bin and outputs d[3:0], bout, ovf.
REQ-031 SHALL keep nibble_sub as the only arithmetic in the block; the controller SHALL hold registers and muxes only.

Verification
REQ-032 SHALL cover a=16'h0009, b=16'h0003, start -> done 5 cycles later, diff=16'h0006, borrow_out=0, overflow=0, zero=0.
REQ-033 SHALL cover a=16'h0004, b=16'h0006 -> diff=16'hFFFE, borrow_out=1, overflow=0.
REQ-034 SHALL cover a=16'h7FFF, b=16'h8000 -> diff=16'hFFFF, borrow_out=1, overflow=1 (overflow=0 when SUB_SEQ_OVERFLOW_EN is undefined); then a=16'h8000, b=16'h0001 -> diff=16'h7FFF, borrow_out=0, overflow=1.
REQ-035 SHALL cover a=16'h1234, b=16'h1234 -> diff=0, zero=1; a start issued in DONE with a=16'h0010, b=16'h0001 -> diff=16'h000F on the next done.
REQ-036 SHALL cover start re-pulsed with new operands during RUN -> ignored, result from the original operands, exactly one done.
REQ-037 SHALL cover rst asserted on the 2nd RUN cycle -> all outputs 0 on the next cycle, no done, next operation correct.
